// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types and constants for the deserializer
//
// Purpose: holds the deserializer FSM state type and the width of the
//          optional error counter.
// Ports:   none (package).
package deser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel frame receiver with valid/ready output
//
// Purpose: waits for a one-cycle start_in pulse, shifts in WIDTH bits LSB-first
//          on the following WIDTH cycles and offers the rebuilt word on a
//          single-entry valid/ready output register. Flags frames aborted by an
//          early start_in (framing_err) and words dropped because the output
//          was still full (overrun).
// Ports:
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          synchronous active-low reset
//   serial_in    in   1          serial data, LSB first
//   start_in     in   1          frame sync, high one cycle before bit 0
//   m_data       out  WIDTH      rebuilt parallel word
//   m_valid      out  1          m_data holds an unconsumed word
//   m_ready      in   1          consumer accepts m_data when m_valid && m_ready
//   framing_err  out  1          one-cycle pulse, frame aborted by early start_in
//   overrun      out  1          one-cycle pulse, completed word dropped
//   err_clr      in   1          (DESER_ERR_CNT_EN only) synchronous counter clear
//   err_cnt      out  ERR_CNT_W  (DESER_ERR_CNT_EN only) saturating error count
// Configuration: define DESER_ERR_CNT_EN to add err_clr/err_cnt.
module deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start_in,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             framing_err,
  output logic             overrun
`ifdef DESER_ERR_CNT_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  deser_state_t     state, state_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next;
  // The last bit is never stored: it is taken straight from serial_in when
  // the word completes, so only WIDTH-1 bits need holding.
  logic [WIDTH-2:0] shift, shift_next;
  logic             word_done;
  logic             frame_abort;
  logic             overrun_next;
  logic             accept;
  logic [WIDTH-1:0] word;

  assign word         = {serial_in, shift};
  assign accept       = word_done && (!m_valid || m_ready);
  assign overrun_next = word_done && m_valid && !m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = bit_cnt;
    shift_next  = shift;
    word_done   = 1'b0;
    frame_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          state_next = RECV;
          cnt_next   = '0;
        end
      end
      RECV: begin
        if (start_in) begin
          // Resync: drop the partial frame; the next cycle carries bit 0.
          frame_abort = 1'b1;
          cnt_next    = '0;
        end else if (bit_cnt == LAST_BIT) begin
          word_done  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          for (int i = 0; i < WIDTH - 1; i++) begin
            if (bit_cnt == CNT_W'(i)) shift_next[i] = serial_in;
          end
          cnt_next = bit_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data      <= '0;
      m_valid     <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= frame_abort;
      overrun     <= overrun_next;
      if (accept) begin
        m_data  <= word;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef DESER_ERR_CNT_EN
  // Counts on the same edge that registers the pulses, so err_cnt and the
  // pulse outputs change together.
  logic [ERR_CNT_W:0] err_sum;
  assign err_sum = {1'b0, err_cnt}
                 + (ERR_CNT_W + 1)'(frame_abort)
                 + (ERR_CNT_W + 1)'(overrun_next);

  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_cnt <= '0;
    end else if (err_sum[ERR_CNT_W]) begin
      err_cnt <= '1;
    end else begin
      err_cnt <= err_sum[ERR_CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - self-checking bench for deserializer (WIDTH=8)
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic       start_in;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       framing_err;
  logic       overrun;
`ifdef DESER_ERR_CNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  deserializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .start_in    (start_in),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .framing_err (framing_err),
    .overrun     (overrun)
`ifdef DESER_ERR_CNT_EN
    ,
    .err_clr     (err_clr),
    .err_cnt     (err_cnt)
`endif
  );

  // One entry per clock: what is driven, plus what the frame-level generator
  // knows happens on that edge (a full frame ends, or a frame is aborted).
  typedef struct {
    bit         st;
    bit         sb;
    bit         rd;
    bit         rs;
    bit         clr;
    bit         done;
    bit         abort;
    logic [7:0] word;
  } cyc_t;

  cyc_t sched[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference output slot and error count
  bit         mv  = 0;
  logic [7:0] md  = 0;
  int         cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pick(input int m);
    if (m == 2) return ($urandom % 4) != 0;
    return m[0];
  endfunction

  task automatic push(input bit st, input bit sb, input bit rd, input bit rs = 0,
                      input bit done = 0, input logic [7:0] word = 8'h00,
                      input bit abort = 0, input bit clr = 0);
    cyc_t c;
    c.st = st; c.sb = sb; c.rd = rd; c.rs = rs;
    c.done = done; c.word = word; c.abort = abort; c.clr = clr;
    sched.push_back(c);
  endtask

  task automatic idle(input int n, input int rdm);
    repeat (n) push(0, bit'($urandom % 2), pick(rdm));
  endtask

  // n data bits of d; a frame completes only when all 8 are sent
  task automatic bits(input logic [7:0] d, input int n, input int rdm, input int rdl);
    for (int i = 0; i < n; i++)
      push(0, d[i], (i == 7) ? pick(rdl) : pick(rdm), 0, (i == 7), d);
  endtask

  task automatic frame(input logic [7:0] d, input int rdm, input int rdl);
    push(1, bit'($urandom % 2), pick(rdm));
    bits(d, 8, rdm, rdl);
  endtask

  task automatic abort_start(input int rdm);
    push(1, bit'($urandom % 2), pick(rdm), 0, 0, 8'h00, 1);
  endtask

  task automatic run();
    bit exp_fe, exp_ov;
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      rst_n     = !sched[i].rs;
      start_in  = sched[i].st;
      serial_in = sched[i].sb;
      m_ready   = sched[i].rd;
`ifdef DESER_ERR_CNT_EN
      err_clr   = sched[i].clr;
`endif
      @(posedge clk);
      #1;
      exp_fe = 0;
      exp_ov = 0;
      if (sched[i].rs) begin
        mv  = 0;
        md  = 0;
        cnt = 0;
      end else begin
        exp_fe = sched[i].abort;
        if (sched[i].done) begin
          if (!mv || sched[i].rd) begin
            md = sched[i].word;
            mv = 1;
          end else begin
            exp_ov = 1;
          end
        end else if (mv && sched[i].rd) begin
          mv = 0;
        end
        if (sched[i].clr) cnt = 0;
        else cnt = (cnt + exp_fe + exp_ov > 255) ? 255 : cnt + exp_fe + exp_ov;
      end
      check("m_valid", m_valid, mv);
      check("m_data", m_data, md);
      check("framing_err", framing_err, exp_fe);
      check("overrun", overrun, exp_ov);
`ifdef DESER_ERR_CNT_EN
      check("err_cnt", err_cnt, cnt);
`endif
    end
    sched.delete();
  endtask

  initial begin
    int ab;
    logic [7:0] d;
    rst_n = 0; start_in = 0; serial_in = 0; m_ready = 0;
`ifdef DESER_ERR_CNT_EN
    err_clr = 0;
`endif
    // reset state
    push(0, 0, 0, 1);
    push(0, 0, 0, 1);
    // single A5 frame, always ready
    idle(3, 1);
    frame(8'hA5, 1, 1);
    idle(3, 1);
    // back-to-back 3C frames, 10-cycle period
    repeat (4) begin frame(8'h3C, 1, 1); idle(1, 1); end
    // resync after 4 bits of FF, then 12
    push(1, 0, 1);
    bits(8'hFF, 4, 1, 1);
    abort_start(1);
    bits(8'h12, 8, 1, 1);
    idle(2, 1);
    // consumer stalled: 22 dropped, 11 kept
    frame(8'h11, 0, 0);
    frame(8'h22, 0, 0);
    idle(2, 0);
    idle(2, 1);
    // ready only on the completion edge of 22
    frame(8'h11, 0, 0);
    push(1, 0, 0);
    bits(8'h22, 8, 0, 1);
    idle(2, 0);
    idle(2, 1);
    // start on the last-bit edge aborts the frame
    push(1, 0, 1);
    bits(8'h77, 7, 1, 1);
    abort_start(1);
    bits(8'h81, 8, 1, 1);
    idle(2, 1);
    // error counter clear
    push(0, 0, 1, 0, 0, 8'h00, 0, 1);
    // reset in the middle of a frame, then 5A
    push(1, 0, 1);
    bits(8'hC3, 5, 1, 1);
    push(0, 1, 1, 1);
    idle(2, 1);
    frame(8'h5A, 1, 1);
    idle(2, 1);
    run();

    // randomized frames, gaps, resyncs and back-pressure
    while (sched.size() < 2500) begin
      idle($urandom_range(0, 3), 2);
      push(1, bit'($urandom % 2), pick(2));
      forever begin
        d  = 8'($urandom);
        ab = (($urandom % 4) == 0) ? $urandom_range(0, 7) : 8;
        bits(d, ab, 2, 2);
        if (ab == 8) break;
        abort_start(2);
      end
    end
    idle(4, 1);
    run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
